// File: rtl/msx_slot_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : msx_slot_pkg
//  Purpose  : Shared constants, slot index type and mapper reset helper for
//             the MSX slot expander / memory mapper.
//  Revision : 1.0 - initial release
// ============================================================================
package msx_slot_pkg;

    // Secondary slot register location in the CPU address space
    localparam logic [15:0] ADDR_SUBSLOT_REG = 16'hFFFF;

    // First I/O port of the four mapper segment registers (0xFC..0xFF)
    localparam logic [7:0]  MAPPER_PORT_BASE = 8'hFC;

    // Two-bit primary/secondary slot or page index
    typedef logic [1:0] slot_idx_t;

    // Power-up segment for mapper page k: (3 - k) mod 2^bits, so the
    // classic 64 KB layout (segments 3,2,1,0) appears after reset.
    function automatic logic [7:0] seg_reset(input int k, input int bits);
        logic [7:0] mask;
        mask = 8'((32'd1 << bits) - 32'd1);
        return 8'(3 - k) & mask;
    endfunction

endpackage : msx_slot_pkg
`default_nettype wire

// File: rtl/msx_wr_edge.sv
`default_nettype none
// ============================================================================
//  Module   : msx_wr_edge
//  Purpose  : One-shot write qualifier. A level write strobe, however many
//             clock cycles it is held, yields exactly one commit edge.
//  Revision : 1.0 - initial release
// ============================================================================
module msx_wr_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_strobe,
    output logic o_commit
);

    logic r_armed;

    // Commit is taken on the edge where the strobe is seen while armed.
    assign o_commit = i_strobe & r_armed;

    // Disarm on commit; re-arm only after the strobe is seen low. Reset
    // leaves the flag disarmed so a strobe straddling reset is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed <= 1'b0;
        end else if (o_commit) begin
            r_armed <= 1'b0;
        end else if (!i_strobe) begin
            r_armed <= 1'b1;
        end
    end

endmodule : msx_wr_edge
`default_nettype wire

// File: rtl/msx_slot_expander.sv
`default_nettype none
// ============================================================================
//  Module   : msx_slot_expander
//  Purpose  : Primary slot decode, MSX2 secondary slot registers at 0xFFFF
//             and a RAM memory mapper with segment registers at I/O
//             0xFC..0xFF. All selects and readback are combinational.
//  Revision : 1.0 - initial release
// ============================================================================
module msx_slot_expander
    import msx_slot_pkg::*;
#(
    parameter logic [3:0] EXPANDED    = 4'b1000,
    parameter int         MAPPER_BITS = 3,
    parameter int         MAPPER_SLOT = 3,
    parameter int         MAPPER_SUB  = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [15:0]               addr,
    input  logic [7:0]                din,
    input  logic                      mreq_n,
    input  logic                      iorq_n,
    input  logic                      rd_n,
    input  logic                      wr_n,
    input  logic                      rfrsh_n,
    input  logic                      m1_n,
    input  logic [7:0]                prim_sel,
    output logic [3:0]                SLTSL_n,
    output logic [15:0]               SUBSL_n,
    output logic                      mapper_cs_n,
    output logic [MAPPER_BITS+13:0]   mapper_a,
    output logic [7:0]                dout,
    output logic                      dout_oe
);

    localparam int c_map_sub_idx = 4 * MAPPER_SLOT + MAPPER_SUB;
    localparam bit c_map_exp     = EXPANDED[MAPPER_SLOT];

    logic                         w_mem;
    logic                         w_io;
    logic                         w_ffff_hit;
    logic                         w_ffff_wr;
    logic                         w_io_wr;
    logic                         w_ffff_commit;
    logic                         w_io_commit;
    slot_idx_t                    w_page;
    slot_idx_t                    w_p;
    slot_idx_t                    w_q;
    slot_idx_t                    w_s;
    logic [3:0][7:0]              w_sec;
    logic [3:0][MAPPER_BITS-1:0]  w_seg;
    logic [7:0]                   w_io_byte;

    // Bus qualification and address decode.
    always_comb begin
        w_mem      = ~mreq_n & rfrsh_n;
        w_io       = ~iorq_n & m1_n & (addr[7:2] == MAPPER_PORT_BASE[7:2]);
        w_page     = addr[15:14];
        w_p        = prim_sel[{w_page, 1'b0} +: 2];
        w_q        = prim_sel[7:6];
        w_ffff_hit = w_mem & (addr == ADDR_SUBSLOT_REG) & EXPANDED[w_q];
        w_ffff_wr  = w_ffff_hit & ~wr_n;
        w_io_wr    = w_io & ~wr_n;
        w_s        = w_sec[w_p][{w_page, 1'b0} +: 2];
    end

    msx_wr_edge u_ffff_edge (
        .clk      (clk),
        .rst      (reset),
        .i_strobe (w_ffff_wr),
        .o_commit (w_ffff_commit)
    );

    msx_wr_edge u_io_edge (
        .clk      (clk),
        .rst      (reset),
        .i_strobe (w_io_wr),
        .o_commit (w_io_commit)
    );

    // Secondary slot registers exist only for expanded primary slots;
    // the others read as zero and never decode a subslot.
    for (genvar p = 0; p < 4; p++) begin : g_sec
        if (EXPANDED[p]) begin : g_exp
            logic [7:0] r_sec;
            // Capture the 0xFFFF write into the slot addressed by prim_sel[7:6].
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_sec <= 8'h00;
                end else if (w_ffff_commit && (w_q == 2'(p))) begin
                    r_sec <= din;
                end
            end
            assign w_sec[p] = r_sec;
        end else begin : g_flat
            assign w_sec[p] = 8'h00;
        end
    end

    // Mapper segment registers, one per 16 KB page.
    for (genvar k = 0; k < 4; k++) begin : g_seg
        localparam logic [7:0] c_seg_rst = seg_reset(k, MAPPER_BITS);
        logic [MAPPER_BITS-1:0] r_seg;
        // Capture the mapper port write addressed by addr[1:0].
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_seg <= c_seg_rst[MAPPER_BITS-1:0];
            end else if (w_io_commit && (addr[1:0] == 2'(k))) begin
                r_seg <= din[MAPPER_BITS-1:0];
            end
        end
        assign w_seg[k] = r_seg;
    end

    // Primary and secondary selects; the 0xFFFF register access itself
    // deselects the slot it targets.
    always_comb begin
        SLTSL_n = 4'hF;
        SUBSL_n = 16'hFFFF;
        if (w_mem && !w_ffff_hit) begin
            SLTSL_n[w_p] = 1'b0;
            if (EXPANDED[w_p]) begin
                SUBSL_n[{w_p, w_s}] = 1'b0;
            end
        end
    end

    // Mapper RAM select and address.
    assign mapper_cs_n = ~(~SLTSL_n[MAPPER_SLOT] & (~c_map_exp | ~SUBSL_n[c_map_sub_idx]));
    assign mapper_a    = {w_seg[w_page], addr[13:0]};

    // Readback: inverted secondary register, or segment padded with ones.
    always_comb begin
        w_io_byte                    = 8'hFF;
        w_io_byte[MAPPER_BITS-1:0]   = w_seg[addr[1:0]];
        dout                         = 8'h00;
        dout_oe                      = 1'b0;
        if (!reset && !rd_n) begin
            if (w_ffff_hit) begin
                dout    = ~w_sec[w_q];
                dout_oe = 1'b1;
            end else if (w_io) begin
                dout    = w_io_byte;
                dout_oe = 1'b1;
            end
        end
    end

endmodule : msx_slot_expander
`default_nettype wire

// File: tb/tb_msx_slot_expander.sv
`default_nettype none
// ============================================================================
//  Module   : tb_msx_slot_expander
//  Purpose  : Scoreboard bench for msx_slot_expander. Two instances share
//             the bus: one with slot 3 expanded, one with no expansion.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_msx_slot_expander;

    localparam int         MB    = 3;
    localparam logic [3:0] EXP_A = 4'b1000;
    localparam logic [3:0] EXP_B = 4'b0000;

    typedef struct packed {
        logic [3:0]    sl;
        logic [15:0]   sub;
        logic          cs;
        logic [MB+13:0] ma;
        logic [7:0]    d;
        logic          oe;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  din = 8'h00;
    logic        mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    logic        rfrsh_n = 1'b1, m1_n = 1'b1;
    logic [7:0]  prim_sel = 8'h00;

    logic [3:0]    a_sl,  b_sl;
    logic [15:0]   a_sub, b_sub;
    logic          a_cs,  b_cs;
    logic [MB+13:0] a_ma, b_ma;
    logic [7:0]    a_d,   b_d;
    logic          a_oe,  b_oe;

    // Reference state
    logic [7:0]    m_sec [4];
    logic [MB-1:0] m_seg [4];

    exp_t  q_a[$];
    exp_t  q_b[$];
    string q_nm[$];
    event  ev_sample;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    msx_slot_expander #(.EXPANDED(EXP_A), .MAPPER_BITS(MB), .MAPPER_SLOT(3), .MAPPER_SUB(0)) u_dut_a (
        .clk(clk), .reset(reset), .addr(addr), .din(din),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .rfrsh_n(rfrsh_n), .m1_n(m1_n), .prim_sel(prim_sel),
        .SLTSL_n(a_sl), .SUBSL_n(a_sub), .mapper_cs_n(a_cs), .mapper_a(a_ma),
        .dout(a_d), .dout_oe(a_oe)
    );

    msx_slot_expander #(.EXPANDED(EXP_B), .MAPPER_BITS(MB), .MAPPER_SLOT(3), .MAPPER_SUB(0)) u_dut_b (
        .clk(clk), .reset(reset), .addr(addr), .din(din),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .rfrsh_n(rfrsh_n), .m1_n(m1_n), .prim_sel(prim_sel),
        .SLTSL_n(b_sl), .SUBSL_n(b_sub), .mapper_cs_n(b_cs), .mapper_a(b_ma),
        .dout(b_d), .dout_oe(b_oe)
    );

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int k = 0; k < 4; k++) begin
            m_sec[k] = 8'h00;
            m_seg[k] = MB'((3 - k) % (1 << MB));
        end
    endfunction

    function automatic exp_t model(input logic [3:0] expm, input bit use_sec);
        exp_t e;
        int page, p, q, s;
        bit mem, ffff, io;
        logic [7:0] sv;
        mem  = !mreq_n && rfrsh_n;
        page = int'(addr) / 16384;
        p    = (int'(prim_sel) >> (2 * page)) % 4;
        q    = int'(prim_sel) / 64;
        ffff = mem && (addr == 16'hFFFF) && expm[q];
        io   = !iorq_n && m1_n && (addr[7:0] >= 8'hFC);
        e.sl  = 4'hF;
        e.sub = 16'hFFFF;
        if (mem && !ffff) begin
            e.sl[p] = 1'b0;
            if (expm[p]) begin
                sv = use_sec ? m_sec[p] : 8'h00;
                s  = (int'(sv) >> (2 * page)) % 4;
                e.sub[4 * p + s] = 1'b0;
            end
        end
        e.cs = !(e.sl[3] == 1'b0 && (!expm[3] || e.sub[12] == 1'b0));
        e.ma = {m_seg[page], addr[13:0]};
        e.d  = 8'h00;
        e.oe = 1'b0;
        if (!reset && !rd_n) begin
            if (ffff) begin
                sv   = use_sec ? m_sec[q] : 8'h00;
                e.d  = ~sv;
                e.oe = 1'b1;
            end else if (io) begin
                e.d  = 8'(8'hFF << MB) | 8'(m_seg[int'(addr[1:0])]);
                e.oe = 1'b1;
            end
        end
        return e;
    endfunction

    // One commit per write access (only the expanded instance owns sec).
    function automatic void model_write();
        int q;
        q = int'(prim_sel) / 64;
        if (!wr_n && !mreq_n && rfrsh_n && addr == 16'hFFFF && EXP_A[q])
            m_sec[q] = din;
        if (!wr_n && !iorq_n && m1_n && addr[7:0] >= 8'hFC)
            m_seg[int'(addr[1:0])] = din[MB-1:0];
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic bus_idle();
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
        rfrsh_n = 1'b1; m1_n = 1'b1;
    endtask

    task automatic push_sample(input string nm);
        q_a.push_back(model(EXP_A, 1'b1));
        q_b.push_back(model(EXP_B, 1'b0));
        q_nm.push_back(nm);
        ->ev_sample;
    endtask

    // kind: 0 mem rd, 1 mem wr, 2 io rd, 3 io wr, 4 refresh wr, 5 io rd with m1_n low
    task automatic access(input int kind, input logic [15:0] a, input logic [7:0] d, input string nm);
        @(posedge clk); #1;
        addr = a;
        din  = d;
        case (kind)
            0: begin mreq_n = 1'b0; rd_n = 1'b0; end
            1: begin mreq_n = 1'b0; wr_n = 1'b0; end
            2: begin iorq_n = 1'b0; rd_n = 1'b0; end
            3: begin iorq_n = 1'b0; wr_n = 1'b0; end
            4: begin mreq_n = 1'b0; rfrsh_n = 1'b0; wr_n = 1'b0; end
            default: begin iorq_n = 1'b0; rd_n = 1'b0; m1_n = 1'b0; end
        endcase
        push_sample(nm);
        @(posedge clk);
        model_write();
        #1;
        bus_idle();
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t ea, eb;
        string nm;
        forever begin
            @(ev_sample);
            @(negedge clk);
            ea = q_a.pop_front();
            eb = q_b.pop_front();
            nm = q_nm.pop_front();
            chk({nm, ".A.sltsl"}, 32'(a_sl),  32'(ea.sl));
            chk({nm, ".A.subsl"}, 32'(a_sub), 32'(ea.sub));
            chk({nm, ".A.cs"},    32'(a_cs),  32'(ea.cs));
            chk({nm, ".A.ma"},    32'(a_ma),  32'(ea.ma));
            chk({nm, ".A.dout"},  32'(a_d),   32'(ea.d));
            chk({nm, ".A.oe"},    32'(a_oe),  32'(ea.oe));
            chk({nm, ".B.sltsl"}, 32'(b_sl),  32'(eb.sl));
            chk({nm, ".B.subsl"}, 32'(b_sub), 32'(eb.sub));
            chk({nm, ".B.cs"},    32'(b_cs),  32'(eb.cs));
            chk({nm, ".B.ma"},    32'(b_ma),  32'(eb.ma));
            chk({nm, ".B.dout"},  32'(b_d),   32'(eb.d));
            chk({nm, ".B.oe"},    32'(b_oe),  32'(eb.oe));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] ra;
        logic [7:0]  rp;
        model_reset();
        bus_idle();

        // Reads while reset is held: no readback enable
        access(2, 16'h00FC, 8'h00, "in_reset_io");
        access(1, 16'hFFFF, 8'h77, "in_reset_wr");
        model_reset();
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk);

        // Reset state
        prim_sel = 8'h00;
        access(0, 16'h4000, 8'h00, "rst_mem4000");
        for (int i = 0; i < 4; i++)
            access(2, 16'h00FC + 16'(i), 8'h00, "rst_io");

        // Secondary register write/readback and subslot decode per page
        prim_sel = 8'hC0;
        access(1, 16'hFFFF, 8'h1B, "sec_wr");
        access(0, 16'hFFFF, 8'h00, "sec_rd");
        prim_sel = 8'hFF;
        for (int pg = 0; pg < 4; pg++)
            access(0, 16'(pg * 16'h4000), 8'h00, "sub_page");

        // Unexpanded instance sees 0xFFFF as ordinary memory
        prim_sel = 8'hC0;
        access(1, 16'hFFFF, 8'h55, "unexp_wr");
        access(0, 16'hFFFF, 8'h00, "unexp_rd");

        // Mapper paging through slot 3 sub 0
        prim_sel = 8'hF0;
        access(1, 16'hFFFF, 8'h00, "map_sec0");
        access(3, 16'h12FE, 8'h05, "map_io_wr");
        access(0, 16'h8123, 8'h00, "map_rd8123");

        // Long write strobe with data changing mid-strobe: one commit only
        @(posedge clk); #1;
        addr = 16'h00FE; din = 8'h01; iorq_n = 1'b0; wr_n = 1'b0;
        push_sample("long_wr");
        @(posedge clk);
        model_write();
        repeat (5) @(posedge clk);
        #1 din = 8'h02;
        repeat (6) @(posedge clk);
        #1 bus_idle();
        access(2, 16'h00FE, 8'h00, "long_wr_rd");

        // Reset asserted in the middle of a 0xFFFF write
        access(1, 16'hFFFF, 8'h3C, "pre_rst_sec");
        @(posedge clk); #1;
        prim_sel = 8'hC0; addr = 16'hFFFF; din = 8'hA5; mreq_n = 1'b0; wr_n = 1'b0;
        #2 reset = 1'b1;
        model_reset();
        push_sample("rst_mid_wr");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 bus_idle();
        access(0, 16'hFFFF, 8'h00, "post_rst_sec");
        for (int i = 0; i < 4; i++)
            access(2, 16'h00FC + 16'(i), 8'h00, "post_rst_io");

        // Refresh cycle at 0xFFFF: nothing selected, nothing written
        access(1, 16'hFFFF, 8'h96, "ref_pre");
        access(4, 16'hFFFF, 8'h00, "refresh");
        access(0, 16'hFFFF, 8'h00, "ref_rd");

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            prim_sel = 8'($urandom);
            ra = ($urandom_range(0, 1) == 0) ? 16'hFFFF : 16'($urandom);
            rp = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {6'h3F, 2'($urandom)};
            case ($urandom_range(0, 5))
                0: access(0, ra, 8'h00, "rnd_mrd");
                1: access(1, ra, 8'($urandom), "rnd_mwr");
                2: access(2, {8'($urandom), rp}, 8'h00, "rnd_iord");
                3: access(3, {8'($urandom), rp}, 8'($urandom), "rnd_iowr");
                4: access(4, ra, 8'($urandom), "rnd_refresh");
                default: access(5, {8'($urandom), rp}, 8'h00, "rnd_inta");
            endcase
        end

        repeat (3) @(posedge clk);
        n_vec++;
        if (q_a.size() != 0) begin
            n_err++;
            $display("FAIL queue_drain: got %0d pending expected 0", q_a.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_msx_slot_expander
`default_nettype wire

// File: doc/msx_slot_expander.md
# msx_slot_expander

Parametrised slot-select and memory-mapper block for the MSX core, the successor of the fixed primary-slot decoder. It decodes the primary slot register (PPI port A) and adds MSX2-style secondary-slot registers at 0xFFFF for any subset of primary slots. It also adds a RAM memory mapper with I/O page registers at 0xFC–0xFF and a configurable segment width. It sits between the T80 bus and the slot devices: ROM, RAM, and the cartridges.

## Interface
- EXPANDED, 4'b1000, bit p set = primary slot p is expanded (has a secondary register)
- MAPPER_BITS, 3, segment register width; mapper size = 16 KB × 2^MAPPER_BITS (1..8)
- MAPPER_SLOT, 3, primary slot holding the mapper RAM
- MAPPER_SUB, 0, subslot holding the mapper RAM (ignored if MAPPER_SLOT not expanded)

Ports:
- clk  in  1  system clock; one clock domain
- reset  in  1  asynchronous, active-high reset
- addr  in  16  CPU address
- din  in  8  CPU write data
- mreq_n, iorq_n, rd_n, wr_n, rfrsh_n, m1_n  in  1 each  T80 bus strobes
- prim_sel  in  8  primary slot register (2 bits per page, page 0 in [1:0])
- SLTSL_n  out  4  primary slot selects, active low
- SUBSL_n  out  16  subslot selects, index 4·p+s, active low
- mapper_cs_n  out  1  mapper RAM select, active low
- mapper_a  out  MAPPER_BITS+14  mapper RAM address {segment, addr[13:0]}
- dout  out  8  readback data
- dout_oe  out  1  dout valid; CPU mux gives this priority

## Operation
- page = addr[15:14]; p = prim_sel[2·page+1:2·page].
- mem = ~mreq_n & rfrsh_n. When mem is high, SLTSL_n[p] = 0; otherwise all SLTSL_n = 1.
- Secondary registers sec[p], 8 bits each, exist only for expanded p. Reset value 0x00.
- FFFF access applies when addr = 0xFFFF, mem is high, and prim_sel[7:6] = q is expanded:
  - Write: sec[q] ← din.
  - Read: dout = ~sec[q], dout_oe = 1.
  - In both cases SLTSL_n[q] and SUBSL_n stay 1 for that access.
  - If q is not expanded, 0xFFFF is an ordinary address.
- SUBSL_n[4p+s] = 0 iff SLTSL_n[p] = 0, p is expanded, and s = sec[p][2·page+1:2·page].
- Mapper segment registers seg[0..3] are MAPPER_BITS wide. Reset values are seg[k] = (3−k) mod 2^MAPPER_BITS.
- Mapper I/O port is active when ~iorq_n & m1_n & addr[7:2] = 6'b111111:
  - Write: seg[addr[1:0]] ← din[MAPPER_BITS−1:0].
  - Read: dout = {1's, seg[addr[1:0]]}, dout_oe = 1.
- mapper_cs_n = 0 iff the mapper slot (and subslot, when expanded) is selected for the current page.
- mapper_a = {seg[page], addr[13:0]}.
- Writes are edge-qualified: each bus write strobe commits exactly once, no matter how many clk cycles wr_n is held low.

## Timing
- Selects, mapper_a and dout are combinational from the bus inputs and current register state. No added latency.
- Register writes commit on the first rising clk edge at which the qualified write strobe is high. The new value is visible from the next cycle.
- Edge detector: armed flag is cleared on commit and re-armed once the strobe is low. Reset sets the flag to "disarmed", so an access straddling reset release is ignored.
- Reset (async) immediately forces:
  - sec[*] = 0x00
  - seg[k] to its reset value
  - dout_oe = 0
  - outputs re-derived from the reset state
- Refresh cycles (rfrsh_n = 0): all selects are 1 and no write is captured.
- A prim_sel change mid-access takes effect combinationally. Write targeting uses q as sampled at the commit edge.

## Structure
- Package msx_slot_pkg holds:
  - ADDR_SUBSLOT_REG = 16'hFFFF
  - MAPPER_PORT_BASE = 8'hFC
  - the seg reset function
  - the typedef for a 2-bit slot index
- Sub-module msx_wr_edge: one-shot write strobe qualifier. Instantiated twice, once for the FFFF write and once for the mapper I/O write.

## Test plan
- Reset check: after reset, with prim_sel = 0x00, a read of 0x4000 gives SLTSL_n = 4'b1110 and SUBSL_n all 1. I/O reads of 0xFC..0xFF return 0xFB, 0xFA, 0xF9, 0xF8 (MAPPER_BITS = 3).
- Secondary register write/readback: prim_sel = 0xC0, write 0xFFFF ← 0x1B, read 0xFFFF → 0xE4 with dout_oe = 1. Then with prim_sel = 0xFF, accesses to pages 0..3 assert SUBSL_n index 15, 14, 13, 12 respectively.
- Unexpanded slot: EXPANDED = 4'b0000, write 0xFFFF ← 0x55 → SLTSL_n[3] = 0 during the write, no register change, dout_oe stays 0.
- Mapper paging: write I/O 0xFE ← 0x05, then read 0x8123 in slot 3 sub 0 → mapper_cs_n = 0, mapper_a = 0x14123.
- Single commit: wr_n held low for 12 clk while din changes from 0x01 to 0x02 mid-strobe → seg holds 0x01 (value at commit edge).
- Reset and refresh: reset asserted mid-write → registers return to reset values, and the straddling write is not committed after release. A refresh cycle at 0xFFFF leaves all selects at 1 and sec unchanged.
